cache_dfp_arbiter: RTL
======================

# cache_dfp_arbiter

Two-requester arbiter that shares the single line-wide memory port between the instruction cache and data cache, both of which use the `dfp_*` request/response protocol. It sits between the caches' downward-facing ports and the memory model / burst adapter. It grants one requester at a time, forwards that requester's line read or write unchanged, and returns the memory response only to the granted requester. Arbitration is round-robin, so neither cache starves when misses are back-to-back.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 32: byte address width.
- `LINE_WIDTH`, default 256: cache line width in bits.

**Ports**
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `i_addr`  in  ADDR_WIDTH: I-cache line address, 32 B aligned.
- `i_read`  in  1: I-cache line read request. Level, held until `i_resp`.
- `i_write`  in  1: I-cache line write request. Always 0 in practice; supported anyway.
- `i_wdata`  in  LINE_WIDTH: I-cache write line.
- `i_rdata`  out  LINE_WIDTH: read line to I-cache.
- `i_resp`  out  1: completion pulse to I-cache.
- `d_addr`, `d_read`, `d_write`, `d_wdata`, `d_rdata`, `d_resp`: D-cache port. Same widths and meaning as the `i_*` port.
- `mem_addr`  out  ADDR_WIDTH: address to memory.
- `mem_read`  out  1: line read strobe to memory.
- `mem_write`  out  1: line write strobe to memory.
- `mem_wdata`  out  LINE_WIDTH: write line to memory.
- `mem_rdata`  in  LINE_WIDTH: read line from memory.
- `mem_resp`  in  1: memory completion, one-cycle pulse.

## Operation

**States**
- `ARB_IDLE`, `ARB_GRANT_I`, `ARB_GRANT_D`. The state register is reset to `ARB_IDLE`.
- Priority pointer `rr_last`, 1 bit: the requester served most recently. Reset value is 1 (D-cache), so the I-cache wins the first tie.

**ARB_IDLE**
- Requesting means `x_read | x_write`.
- No requester → stay in `ARB_IDLE`.
- One requester → go to that requester's grant state.
- Both requesting → grant the requester ≠ `rr_last`.
- All memory outputs are 0. All `*_resp` and `*_rdata` outputs are 0. A `mem_resp` arriving in this state is ignored.

**ARB_GRANT_x**
- `mem_addr`, `mem_read`, `mem_write` and `mem_wdata` combinationally mirror requester x.
- `x_rdata = mem_rdata` and `x_resp = mem_resp`. The other requester sees `rdata = 0` and `resp = 0`.

**Leaving ARB_GRANT_x**
- On `mem_resp`: go to `ARB_IDLE`, set `rr_last = x`.
- If requester x drops both read and write before `mem_resp` (protocol violation, treated as an abort): go to `ARB_IDLE` next cycle, `rr_last` unchanged.

**Other rules**
- A writeback followed by an allocate from the same cache is two separate transactions. The other cache may be granted between them, because `rr_last` flips after the writeback. The D-cache stays correct because it holds `d_read` until its own `d_resp`.
- `x_read` and `x_write` both high is illegal. It is forwarded as-is, and the bench flags it with an assertion.

## Timing

**Latency**
- Request rises in cycle T while the arbiter is in `ARB_IDLE` → grant is registered at the T→T+1 edge → `mem_read`/`mem_write` is first high in T+1.
- `mem_resp` in cycle R → `x_resp` is high in the same cycle R (combinational) → `ARB_IDLE` in R+1 → the next grant's memory strobe is seen in R+2.
- Minimum gap between consecutive memory transactions: one idle cycle.

**Outputs**
- Every output is 0 in `ARB_IDLE` and during reset.
- At most one of `mem_read`/`mem_write` is high per cycle for legal traffic.
- `i_resp` and `d_resp` are never high in the same cycle.

**Reset**
- Reset asserted mid-transaction → `ARB_IDLE` and `rr_last = 1` after the edge. Outputs are 0 from the next cycle.
- A `mem_resp` pulse that arrives in the cycle after reset is dropped. The memory model must also be reset.

## Structure

- Add `arb_state_e` (`ARB_IDLE`, `ARB_GRANT_I`, `ARB_GRANT_D`) to the shared `types` package.
- Add the requester index constants `REQ_I = 1'b0` and `REQ_D = 1'b1` to the same package.
- One sub-module, `rr_pick2`: purely combinational 2-way round-robin select. Inputs `req[1:0]` and `last`; outputs `gnt[1:0]` (one-hot) and `valid`.
- State register, `rr_last`, and output muxing stay in the top module. No datapath registers: line data is never buffered.

## Test plan

1. **Lone I-read.** `i_read=1`, `i_addr=0x0000_1A40` at T.
   - `mem_read=1`, `mem_addr=0x0000_1A40` from T+1.
   - Memory returns `mem_rdata=0xDEAD…BEEF` with `mem_resp` at T+4 → `i_resp=1` and `i_rdata` equal to that line at T+4. `d_resp=0` throughout.
   - Arbiter is in `ARB_IDLE` at T+5.
2. **Simultaneous after reset.** `i_read` and `d_read` both asserted at T.
   - I-cache granted first.
   - After `i_resp`, the D-cache is granted; its `mem_read` appears 2 cycles after `i_resp`.
3. **Round-robin fairness.** Both caches keep requesting continuously for 6 transactions.
   - Grants alternate I, D, I, D, I, D.
   - The `mem_resp` count per cache is 3 each.
4. **D writeback then allocate, with I pending.**
   - `d_write=1`, `d_addr=0x0000_8000`, `d_wdata=0xA5…A5` → `mem_write` with matching address and data.
   - Then `i_read` is served, then the D-cache's `d_read`.
   - No cycle has `mem_read & mem_write`.
5. **Reset mid-grant.** `rst` asserted in the 2nd cycle of `ARB_GRANT_D`.
   - All outputs are 0 the next cycle.
   - A subsequent tie goes to the I-cache.
6. **Abort and stray response.**
   - Granted requester drops its request with no `mem_resp` → arbiter is in `ARB_IDLE` next cycle and `rr_last` is unchanged.
   - A `mem_resp` pulse while in `ARB_IDLE` → both `*_resp` stay 0.

Source files
------------

// File: rtl/cache_dfp_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter: FSM states and requester indices.
package cache_dfp_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/cache_dfp_arbiter_rr_pick2.sv
// Combinational two-way round-robin select: on a tie, grant the requester
// that was not served most recently.
module rr_pick2
  import cache_dfp_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == REQ_D) ? 2'b01 : 2'b10;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/cache_dfp_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache dfp ports.
// One owner at a time; line data passes straight through and is never buffered.
module cache_dfp_arbiter
  import cache_dfp_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic [1:0]            o_dbg_state
);

  arb_state_e r_state;
  logic       r_rr_last;
  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_valid;

  assign w_req = {d_read | d_write, i_read | i_write};

  rr_pick2 u_pick (
    .req   (w_req),
    .last  (r_rr_last),
    .gnt   (w_gnt),
    .valid (w_valid)
  );

  // A dropped request without mem_resp is an abort: release without touching rr_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_rr_last <= REQ_D;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_valid) r_state <= w_gnt[REQ_I] ? ARB_GRANT_I : ARB_GRANT_D;
        end
        ARB_GRANT_I: begin
          if (mem_resp) begin
            r_state   <= ARB_IDLE;
            r_rr_last <= REQ_I;
          end else if (!w_req[REQ_I]) begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_GRANT_D: begin
          if (mem_resp) begin
            r_state   <= ARB_IDLE;
            r_rr_last <= REQ_D;
          end else if (!w_req[REQ_D]) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    i_rdata   = '0;
    i_resp    = 1'b0;
    d_rdata   = '0;
    d_resp    = 1'b0;
    case (r_state)
      ARB_GRANT_I: begin
        mem_addr  = i_addr;
        mem_read  = i_read;
        mem_write = i_write;
        mem_wdata = i_wdata;
        i_rdata   = mem_rdata;
        i_resp    = mem_resp;
      end
      ARB_GRANT_D: begin
        mem_addr  = d_addr;
        mem_read  = d_read;
        mem_write = d_write;
        mem_wdata = d_wdata;
        d_rdata   = mem_rdata;
        d_resp    = mem_resp;
      end
      default: ;
    endcase
  end

  assign o_dbg_state = r_state;

endmodule
